// File: rtl/instr_packer.sv
// Packs single 16/32-bit RISC-V instructions into word-aligned 32-bit fetch words with half-word valids.
// Optional INSTR_PACKER_ALIGN_CHECK_EN: drop odd-addressed inputs and raise sticky error_o.
module instr_packer #(
  parameter int ADDR_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              drain_i,
  input  logic [31:0]       instr_i,
  input  logic [ADDR_W-1:0] instr_addr_i,
  input  logic              instr_valid_i,
  output logic              instr_ready_o,
  output logic [31:0]       word_o,
  output logic [ADDR_W-1:0] word_addr_o,
  output logic [1:0]        word_be_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              error_o
);

`ifdef INSTR_PACKER_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK = 1'b1;
`else
  localparam bit ALIGN_CHECK = 1'b0;
`endif

  typedef enum logic {EMPTY, HALF} state_t;

  state_t            state;
  logic [15:0]       held_q;
  logic [ADDR_W-1:0] addr_q;   // always word-aligned

  logic              is_c, seq, disc, slot_free, accept, misalign, take, drain_go;
  logic [ADDR_W-1:0] waddr;

  assign is_c      = instr_i[1:0] != 2'b11;
  assign waddr     = {instr_addr_i[ADDR_W-1:2], 2'b00};
  // A is word-aligned, so X == A+2 reduces to same word with X[1] set; wrap is implicit
  assign seq       = instr_addr_i[1] & (instr_addr_i[ADDR_W-1:2] == addr_q[ADDR_W-1:2]);
  assign disc      = (state == HALF) & instr_valid_i & ~seq;
  assign slot_free = ~word_valid_o | word_ready_i;
  assign instr_ready_o = slot_free & ~flush_i & ~disc;
  assign accept    = instr_valid_i & instr_ready_o;
  assign misalign  = ALIGN_CHECK & instr_addr_i[0];
  assign take      = accept & ~misalign;
  assign drain_go  = (state == HALF) & drain_i & ~instr_valid_i & slot_free & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state        <= EMPTY;
      held_q       <= '0;
      addr_q       <= '0;
      word_o       <= '0;
      word_addr_o  <= '0;
      word_be_o    <= '0;
      word_valid_o <= 1'b0;
      error_o      <= 1'b0;
    end else begin
      if (accept && misalign) error_o <= 1'b1;
      if (flush_i) begin
        word_valid_o <= 1'b0;
        state        <= EMPTY;
      end else begin
        if (word_ready_i) word_valid_o <= 1'b0;
        if (take) begin
          if (state == EMPTY) begin
            if (!instr_addr_i[1]) begin
              if (is_c) begin
                held_q <= instr_i[15:0];
                addr_q <= waddr;
                state  <= HALF;
              end else begin
                word_o       <= instr_i;
                word_addr_o  <= waddr;
                word_be_o    <= 2'b11;
                word_valid_o <= 1'b1;
              end
            end else begin
              word_o       <= {instr_i[15:0], 16'h0};
              word_addr_o  <= waddr;
              word_be_o    <= 2'b10;
              word_valid_o <= 1'b1;
              if (!is_c) begin
                held_q <= instr_i[31:16];
                addr_q <= waddr + ADDR_W'(4);
                state  <= HALF;
              end
            end
          end else begin
            word_o       <= {instr_i[15:0], held_q};
            word_addr_o  <= addr_q;
            word_be_o    <= 2'b11;
            word_valid_o <= 1'b1;
            if (is_c) begin
              state <= EMPTY;
            end else begin
              held_q <= instr_i[31:16];
              addr_q <= addr_q + ADDR_W'(4);
            end
          end
        end else if ((disc && slot_free) || drain_go) begin
          // flush out the lone held half-word; a refused input retries next cycle
          word_o       <= {16'h0, held_q};
          word_addr_o  <= addr_q;
          word_be_o    <= 2'b01;
          word_valid_o <= 1'b1;
          state        <= EMPTY;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_packer.sv
// Randomized scoreboard bench for instr_packer; model folds a half-word stream into aligned words.
module tb_instr_packer;
  localparam int AW = 64;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          flush_i, drain_i, instr_valid_i, instr_ready_o;
  logic [31:0]   instr_i, word_o;
  logic [AW-1:0] instr_addr_i, word_addr_o;
  logic [1:0]    word_be_o;
  logic          word_valid_o, word_ready_i, error_o;

  instr_packer #(.ADDR_W(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .drain_i(drain_i),
    .instr_i(instr_i), .instr_addr_i(instr_addr_i), .instr_valid_i(instr_valid_i),
    .instr_ready_o(instr_ready_o), .word_o(word_o), .word_addr_o(word_addr_o),
    .word_be_o(word_be_o), .word_valid_o(word_valid_o), .word_ready_i(word_ready_i),
    .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]   w;
    logic [AW-1:0] a;
    logic [1:0]    be;
  } exp_t;

  exp_t          expq[$];
  int            checks = 0, errors = 0;
  bit            p_v = 0;          // model: lower half-word waiting for its partner
  logic [15:0]   p_h;
  logic [AW-1:0] p_a;
  bit            exp_err = 0, exp_err_seen = 0;
  bit            disc_wait = 0;
  bit            run_mon = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endfunction

  function automatic void push(logic [31:0] w, logic [AW-1:0] a, logic [1:0] be);
    exp_t e;
    e.w = w; e.a = a; e.be = be;
    expq.push_back(e);
  endfunction

  function automatic void put_hw(logic [AW-1:0] a, logic [15:0] h);
    logic [AW-1:0] nxt;
    nxt = p_a + 2;
    if (p_v && a != nxt) begin
      push({16'h0, p_h}, p_a, 2'b01);
      p_v = 0;
    end
    if (p_v) begin
      push({h, p_h}, p_a, 2'b11);
      p_v = 0;
    end else if (!a[1]) begin
      p_v = 1; p_h = h; p_a = a;
    end else begin
      push({h, 16'h0}, a - 2, 2'b10);
    end
  endfunction

  function automatic void model_instr(logic [AW-1:0] addr, logic [31:0] ins);
    logic [AW-1:0] a;
`ifdef INSTR_PACKER_ALIGN_CHECK_EN
    if (addr[0]) begin
      exp_err = 1;
      return;
    end
`endif
    a = {addr[AW-1:1], 1'b0};
    put_hw(a, ins[15:0]);
    if (ins[1:0] == 2'b11) put_hw(a + 2, ins[31:16]);
  endfunction

  // monitor: pops expected words on each handshake and checks hold-stability under backpressure
  initial begin : monitor
    bit            stall = 0, pflush = 0;
    logic [31:0]   sw;
    logic [AW-1:0] sa;
    logic [1:0]    sb;
    exp_t          e;
    forever begin
      @(negedge clk_i);
      if (run_mon) begin
        if (word_valid_o) begin
          if (stall) begin
            chk("hold_word", word_o, sw);
            chk("hold_addr", word_addr_o, sa);
            chk("hold_be", word_be_o, sb);
          end
          if (word_ready_i) begin
            if (expq.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_word actual=%h@%h be=%b required=none", word_o, word_addr_o, word_be_o);
            end else begin
              e = expq.pop_front();
              chk("word", word_o, e.w);
              chk("addr", word_addr_o, e.a);
              chk("be", word_be_o, e.be);
            end
          end
          stall = !word_ready_i;
          sw = word_o; sa = word_addr_o; sb = word_be_o;
        end else begin
          if (stall && !pflush) chk("held_word_lost", 1'b0, 1'b1);
          stall = 0;
        end
        chk("error_o", error_o, exp_err_seen);
        pflush = flush_i;
      end
    end
  end

  initial begin : driver
    logic [AW-1:0] pc, cur_a;
    logic [31:0]   cur_i;
    bit            have = 0, disc;
    int            bp = 0, r, n;
    logic [AW-1:0] nxt;

    rst_ni = 0; flush_i = 0; drain_i = 0; instr_valid_i = 0;
    instr_i = '0; instr_addr_i = '0; word_ready_i = 1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_valid", word_valid_o, 1'b0);
    chk("rst_word", word_o, 32'h0);
    chk("rst_addr", word_addr_o, '0);
    chk("rst_be", word_be_o, 2'b00);
    chk("rst_error", error_o, 1'b0);
    chk("rst_ready", instr_ready_o, 1'b1);
    rst_ni = 1;
    run_mon = 1;
    pc = 64'h1000;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk_i); #1;
      exp_err_seen = exp_err;
      flush_i = 0; drain_i = 0;
      r = $urandom_range(0, 99);
      if (r < 3) begin
        flush_i = 1; word_ready_i = 0;
      end else if (!have && r < 10) begin
        drain_i = 1; word_ready_i = 1;
      end else begin
        if (r < 13 && bp == 0) bp = 5;
        if (bp > 0) begin word_ready_i = 0; bp--; end
        else word_ready_i = ($urandom_range(0, 3) != 0);
        if (!have && $urandom_range(0, 3) != 0) begin
          if ($urandom_range(0, 9) == 0)
            pc = ($urandom_range(0, 2) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'(2 * $urandom_range(0, 7))
                                             : ({$urandom, $urandom} & ~64'h1);
          if ($urandom_range(0, 1) == 0)
            cur_i = {16'($urandom), 14'($urandom), 2'($urandom_range(0, 2))};
          else
            cur_i = {30'($urandom), 2'b11};
          cur_a = pc;
`ifdef INSTR_PACKER_ALIGN_CHECK_EN
          if ($urandom_range(0, 19) == 0) cur_a = pc | 64'h1;
`endif
          pc = pc + ((cur_i[1:0] == 2'b11) ? 64'd4 : 64'd2);
          have = 1;
        end
      end
      instr_valid_i = have && !drain_i;
      instr_i = cur_i;
      instr_addr_i = cur_a;

      @(negedge clk_i);
      nxt = p_a + 2;
      disc = instr_valid_i && p_v && ({instr_addr_i[AW-1:1], 1'b0} != nxt);
      if (disc && !flush_i) begin
        chk("disc_ready", instr_ready_o, 1'b0);
        push({16'h0, p_h}, p_a, 2'b01);
        p_v = 0;
        disc_wait = 1;
      end
      if (flush_i) chk("flush_ready", instr_ready_o, 1'b0);
      else if (word_ready_i && !disc_wait) chk("ready", instr_ready_o, 1'b1);
      if (instr_valid_i && instr_ready_o) begin
        model_instr(instr_addr_i, instr_i);
        have = 0;
        disc_wait = 0;
      end
      if (drain_i && p_v) begin
        push({16'h0, p_h}, p_a, 2'b01);
        p_v = 0;
      end
      if (flush_i) begin
        expq.delete();
        p_v = 0;
        disc_wait = 0;
      end
    end

    // let the pending instruction go in, then drain everything out
    n = 0;
    while ((have || p_v || expq.size() != 0) && n < 60) begin
      @(posedge clk_i); #1;
      exp_err_seen = exp_err;
      flush_i = 0; word_ready_i = 1;
      drain_i = !have;
      instr_valid_i = have;
      @(negedge clk_i);
      nxt = p_a + 2;
      if (instr_valid_i && p_v && ({instr_addr_i[AW-1:1], 1'b0} != nxt)) begin
        push({16'h0, p_h}, p_a, 2'b01);
        p_v = 0;
      end
      if (instr_valid_i && instr_ready_o) begin
        model_instr(instr_addr_i, instr_i);
        have = 0;
      end
      if (drain_i && p_v) begin
        push({16'h0, p_h}, p_a, 2'b01);
        p_v = 0;
      end
      n++;
    end
    @(posedge clk_i); #1;
    drain_i = 0; instr_valid_i = 0;
    @(negedge clk_i);
    chk("final_queue_empty", 32'(expq.size()), 32'd0);
    run_mon = 0;

    // asynchronous reset drops the output register immediately
    @(posedge clk_i); #1;
    instr_i = 32'h0000_0013; instr_addr_i = 64'h1000; instr_valid_i = 1; word_ready_i = 0;
    @(posedge clk_i); #1;
    instr_valid_i = 0;
    rst_ni = 0;
    #1;
    chk("async_rst_valid", word_valid_o, 1'b0);
    chk("async_rst_word", word_o, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
